perm_round_sched: RTL



---
 rtl/perm_round_sched.sv | 118 +++++++++++
 1 files changed

// File: rtl/perm_round_sched.sv
// perm_round_sched: sequencing controller for the sLiSCP-light permutation core.
//
// On an accepted start it runs NUM_STEPS steps, each made of ROUNDS_PER_STEP round
// cycles followed by one step-mixing cycle, then emits a one-cycle perm_done pulse.
// A 7-bit LFSR (x^7+x^6+1) supplies the round constant bit and the step constant.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   start       permutation request, sampled every cycle
//   hold        stall; freezes all progress while in ROUND or MIX
//   busy        high in ROUND, MIX and DONE
//   load_state  datapath captures its input state (accept cycle, combinational from start)
//   en_round    datapath executes one round
//   en_mix      datapath executes step mixing
//   round_idx   round within the current step
//   step_idx    current step
//   rc_bit      round constant bit (lfsr[0])
//   sc          step constant (lfsr value), meaningful while en_mix=1
//   perm_done   one-cycle completion pulse
//   start_err   one-cycle pulse when a start is ignored because the core is busy
//
// en_round/en_mix are gated by hold in the same cycle so that a stalled cycle never
// advances the datapath; start_err flags the offending start in its own cycle.
module perm_round_sched #(
  parameter int unsigned ROUNDS_PER_STEP = 6,
  parameter int unsigned NUM_STEPS       = 18,
  parameter logic [6:0]  LFSR_SEED       = 7'h7F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hold,
  output logic       busy,
  output logic       load_state,
  output logic       en_round,
  output logic       en_mix,
  output logic [2:0] round_idx,
  output logic [4:0] step_idx,
  output logic       rc_bit,
  output logic [6:0] sc,
  output logic       perm_done,
  output logic       start_err
);

  localparam logic [2:0] RoundLast = 3'(ROUNDS_PER_STEP - 1);
  localparam logic [4:0] StepLast  = 5'(NUM_STEPS - 1);

  typedef enum logic [1:0] {StIdle, StRound, StMix, StDone} state_e;

  state_e     state_q;
  logic [2:0] round_q;
  logic [4:0] step_q;
  logic [6:0] lfsr_q;
  logic [6:0] lfsr_next;

  assign lfsr_next = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      round_q <= '0;
      step_q  <= '0;
      lfsr_q  <= LFSR_SEED;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            lfsr_q  <= LFSR_SEED;
            round_q <= '0;
            step_q  <= '0;
            state_q <= StRound;
          end
        end
        StRound: begin
          if (!hold) begin
            lfsr_q <= lfsr_next;
            if (round_q == RoundLast) begin
              round_q <= '0;
              state_q <= StMix;
            end else begin
              round_q <= round_q + 3'd1;
            end
          end
        end
        StMix: begin
          // LFSR is not advanced here: sc must equal the value left by the last round.
          if (!hold) begin
            if (step_q == StepLast) begin
              state_q <= StDone;
            end else begin
              step_q  <= step_q + 5'd1;
              state_q <= StRound;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy       = (state_q != StIdle);
  assign load_state = (state_q == StIdle) && start;
  assign en_round   = (state_q == StRound) && !hold;
  assign en_mix     = (state_q == StMix) && !hold;
  assign perm_done  = (state_q == StDone);
  assign start_err  = busy && start;
  assign round_idx  = round_q;
  assign step_idx   = step_q;
  assign rc_bit     = lfsr_q[0];
  assign sc         = lfsr_q;

endmodule
